// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and bubble helpers for the elastic pipeline stage
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0033;
    localparam logic [31:0] PIPE_RESET_PC  = 32'h1000_0000;
    localparam int          PIPE_CTRL_W    = 8;
    localparam int          PIPE_DATA_W    = 128;
    localparam int          PIPE_PERF_W    = 16;

    // Width-independent part of a stage entry; ctrl/data bubbles are all zero
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } stage_hdr_t;

    function automatic stage_hdr_t bubble_hdr(input logic [31:0] nop_instr, input logic [31:0] reset_pc);
        stage_hdr_t h;
        h.instr = nop_instr;
        h.pc    = reset_pc;
        return h;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one stage entry plus valid flop with clear > load > unload priority
module pipe_skid_slot #(
    parameter int           W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clear,
    input  logic         load,
    input  logic         unload,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    // An empty slot always stores the bubble so downstream never sees stale fields
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (unload) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end
    end

endmodule

// File: rtl/pipeline_stage_elastic.sv
// rtl/pipeline_stage_elastic.sv - ready/valid stage register with flush, stall counter and optional
// skid slot enabled by PIPE_SKID_EN
module pipeline_stage_elastic
    import pipe_pkg::*;
#(
    parameter int          CTRL_W    = PIPE_CTRL_W,
    parameter int          DATA_W    = PIPE_DATA_W,
    parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
    parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR,
    parameter int          PERF_W    = PIPE_PERF_W
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } stage_entry_t;

    localparam int           ENTRY_W = $bits(stage_entry_t);
    localparam stage_entry_t BUBBLE  = {bubble_hdr(NOP_INSTR, RESET_PC), {CTRL_W{1'b0}}, {DATA_W{1'b0}}};
    localparam logic [PERF_W-1:0] CNT_MAX = '1;

    stage_entry_t in_entry;
    stage_entry_t main_d;
    stage_entry_t main_q;
    logic         main_valid;
    logic         main_load;
    logic         main_unload;
    logic         xfer_in;
    logic         xfer_out;

    assign in_entry = '{instr: in_instr, pc: in_pc, ctrl: in_ctrl, data: in_data};
    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = main_valid & out_ready;

`ifdef PIPE_SKID_EN
    stage_entry_t skid_q;
    logic         skid_valid;
    logic         skid_load;
    logic         skid_unload;
    logic         main_free;

    // in_ready comes straight from the skid valid flop, breaking the out_ready->in_ready path
    assign main_free   = !main_valid | out_ready;
    assign in_ready    = !skid_valid;
    assign main_load   = main_free & (skid_valid | xfer_in);
    assign main_d      = skid_valid ? skid_q : in_entry;
    assign main_unload = xfer_out;
    assign skid_load   = xfer_in & !main_free;
    assign skid_unload = skid_valid & main_free;

    pipe_skid_slot #(
        .W      (ENTRY_W),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (flush),
        .load   (skid_load),
        .unload (skid_unload),
        .d      (in_entry),
        .q      (skid_q),
        .valid  (skid_valid)
    );
`else
    assign in_ready    = !main_valid | out_ready;
    assign main_load   = xfer_in;
    assign main_d      = in_entry;
    assign main_unload = xfer_out;
`endif

    pipe_skid_slot #(
        .W      (ENTRY_W),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (flush),
        .load   (main_load),
        .unload (main_unload),
        .d      (main_d),
        .q      (main_q),
        .valid  (main_valid)
    );

    assign out_valid = main_valid;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_ctrl  = main_q.ctrl;
    assign out_data  = main_q.data;

    // Saturating counter; survives flush, cleared only by reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// tb/tb_pipeline_stage_elastic.sv - queue-model scoreboard plus directed checks for pipeline_stage_elastic
module tb_pipeline_stage_elastic;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         flush;
    logic         in_valid;
    logic [31:0]  in_instr;
    logic [31:0]  in_pc;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;
    logic         out_ready;

    logic         in_ready, out_valid;
    logic [31:0]  out_instr, out_pc;
    logic [7:0]   out_ctrl;
    logic [127:0] out_data;
    logic [15:0]  stall_cnt;

    logic         in_ready_s, out_valid_s;
    logic [31:0]  out_instr_s, out_pc_s;
    logic [7:0]   out_ctrl_s;
    logic [127:0] out_data_s;
    logic [3:0]   stall_cnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stage_elastic #(.CTRL_W(8), .DATA_W(128), .PERF_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pipeline_stage_elastic #(.CTRL_W(8), .DATA_W(128), .PERF_W(4)) dut_sat (
        .clk(clk), .n_rst(n_rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_instr(in_instr), .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_instr(out_instr_s), .out_pc(out_pc_s),
        .out_ctrl(out_ctrl_s), .out_data(out_data_s), .stall_cnt(stall_cnt_s)
    );

    typedef struct {
        logic [31:0]  instr;
        logic [31:0]  pc;
        logic [7:0]   ctrl;
        logic [127:0] data;
    } ent_t;

    ent_t q[$];
    int   stalls = 0;

`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    function automatic bit m_in_ready();
        if (CAP == 2) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    // Model: a FIFO of capacity CAP; pop on out transfer, push on in transfer, flush empties it
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            stalls = 0;
        end else begin
            bit   rdy;
            ent_t e;
            rdy = m_in_ready();
            e.instr = in_instr; e.pc = in_pc; e.ctrl = in_ctrl; e.data = in_data;
            if (q.size() > 0 && !out_ready) stalls++;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && rdy) q.push_back(e);
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        int   e16, e4;
        if (q.size() > 0) e = q[0];
        else begin
            e.instr = 32'h0000_0033; e.pc = 32'h1000_0000; e.ctrl = '0; e.data = '0;
        end
        e16 = (stalls > 65535) ? 65535 : stalls;
        e4  = (stalls > 15) ? 15 : stalls;
        chk("m_out_valid", out_valid, q.size() > 0);
        chk("m_in_ready",  in_ready,  m_in_ready());
        chk("m_out_instr", out_instr, e.instr);
        chk("m_out_pc",    out_pc,    e.pc);
        chk("m_out_ctrl",  out_ctrl,  e.ctrl);
        chk("m_out_data",  out_data,  e.data);
        chk("m_stall_cnt", stall_cnt, e16);
        chk("m_s_out_valid", out_valid_s, q.size() > 0);
        chk("m_s_in_ready",  in_ready_s,  m_in_ready());
        chk("m_s_out_instr", out_instr_s, e.instr);
        chk("m_s_out_pc",    out_pc_s,    e.pc);
        chk("m_s_out_ctrl",  out_ctrl_s,  e.ctrl);
        chk("m_s_out_data",  out_data_s,  e.data);
        chk("m_s_stall_cnt", stall_cnt_s, e4);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_instr = pc ^ 32'hDEAD_0000;
        in_ctrl  = pc[9:2] ^ 8'h5A;
        in_data  = {4{~pc}};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'h0);
        step(); step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_instr", out_instr, 32'h0000_0033);
        chk("rst_out_pc",    out_pc,    32'h1000_0000);
        chk("rst_out_ctrl",  out_ctrl,  8'h00);
        chk("rst_out_data",  out_data,  128'h0);
        chk("rst_stall_cnt", stall_cnt, 16'h0);
        n_rst = 1'b1;
        step();

        // streaming: one per cycle, one cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 32'h100 + 32'(4 * i));
            step();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_pc",    out_pc,    32'h100 + 32'(4 * i));
        end
        set_in(1'b0, 32'h0);
        step();
        chk("stream_drain", out_valid, 1'b0);

        // stall with a second entry waiting
        out_ready = 1'b0;
        set_in(1'b1, 32'h200);
        step();
        chk("stall_load_pc", out_pc, 32'h200);
        set_in(1'b1, 32'h204);
        for (int k = 1; k <= 5; k++) begin
            step();
`ifdef PIPE_SKID_EN
            if (k == 1) set_in(1'b0, 32'h0);
`endif
            chk("stall_hold_pc", out_pc, 32'h200);
        end
        chk("stall_cnt5",   stall_cnt,   16'd5);
        chk("stall_cnt5_s", stall_cnt_s, 4'd5);
        chk("stall_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        step();
        set_in(1'b0, 32'h0);
        chk("release_valid", out_valid, 1'b1);
        chk("release_pc",    out_pc,    32'h204);
        step();
        chk("release_drain", out_valid, 1'b0);

        // saturation of the narrow counter
        out_ready = 1'b0;
        set_in(1'b1, 32'h240);
        step();
        set_in(1'b0, 32'h0);
        repeat (20) step();
        chk("sat_cnt_s", stall_cnt_s, 4'd15);
        chk("sat_cnt",   stall_cnt,   16'd25);
        step(); step();
        chk("sat_hold_s", stall_cnt_s, 4'd15);
        chk("sat_cnt27",  stall_cnt,   16'd27);
        out_ready = 1'b1;
        step(); step();

        // flush while stalled, with a new input presented
        out_ready = 1'b0;
        set_in(1'b1, 32'h2FC);
        step();
        chk("flush_pre_pc", out_pc, 32'h2FC);
        set_in(1'b1, 32'h300);
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_in(1'b0, 32'h0);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl",  out_ctrl,  8'h00);
        chk("flush_instr", out_instr, 32'h0000_0033);
        chk("flush_pc",    out_pc,    32'h1000_0000);
        out_ready = 1'b1;
        step();
        chk("flush_dropped", out_valid, 1'b0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = $urandom;
            in_instr  = $urandom;
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end

        // asynchronous reset in the middle of a stall
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b1, 32'h400);
        step(); step();
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_instr", out_instr, 32'h0000_0033);
        chk("arst_pc",    out_pc,    32'h1000_0000);
        chk("arst_cnt",   stall_cnt, 16'h0);
        chk("arst_cnt_s", stall_cnt_s, 4'h0);
        set_in(1'b0, 32'h0);
        step();
        n_rst = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'h500);
        step();
        set_in(1'b0, 32'h0);
        chk("post_rst_pc",    out_pc,    32'h500);
        chk("post_rst_valid", out_valid, 1'b1);
        step();
        chk("post_rst_drain", out_valid, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
